// File: rtl/bus_datapath_seq.sv
// Single-bus datapath with a register file, Y/Z ALU staging and HI/LO, run by a
// built-in IDLE/T1/T2/T3/DONE microsequencer issuing one Ra <= Rb op Rc per start.
module bus_datapath_seq #(
  parameter  int WIDTH = 32,
  parameter  int NREGS = 16,
  localparam int AW    = $clog2(NREGS),
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rc,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SHL  = 4'd4;
  localparam logic [3:0] OP_SHR  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_NEG  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_MFHI = 4'd10;
  localparam logic [3:0] OP_MFLO = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [3:0]           op_q;
  logic [AW-1:0]        ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]     regs_q [NREGS];
  logic [WIDTH-1:0]     y_q, hi_q, lo_q, rd_q;
  logic [2*WIDTH-1:0]   z_q;
  logic                 busy_q, done_q, err_q;

  logic [WIDTH-1:0]     b_s;
  logic [SW-1:0]        sh_s;
  logic [2*WIDTH-1:0]   ya_s, yb_s, alu_s;
  logic                 illegal_s, seq_we_s, hilo_we_s;

  assign illegal_s = (op_q > OP_MFLO);
  assign seq_we_s  = (state_q == S_T3) && !illegal_s && (op_q != OP_MUL);
  assign hilo_we_s = (state_q == S_T3) && (op_q == OP_MUL);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_T1;
        else       state_d = S_IDLE;
      end
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // MUL works on sign-extended operands so the low 2*WIDTH product bits are the signed product.
  always_comb begin
    b_s   = regs_q[rc_q];
    sh_s  = b_s[SW-1:0];
    ya_s  = {{WIDTH{y_q[WIDTH-1]}}, y_q};
    yb_s  = {{WIDTH{b_s[WIDTH-1]}}, b_s};
    alu_s = '0;
    case (op_q)
      OP_ADD:  alu_s[WIDTH-1:0] = y_q + b_s;
      OP_SUB:  alu_s[WIDTH-1:0] = y_q - b_s;
      OP_AND:  alu_s[WIDTH-1:0] = y_q & b_s;
      OP_OR:   alu_s[WIDTH-1:0] = y_q | b_s;
      OP_SHL:  alu_s[WIDTH-1:0] = y_q << sh_s;
      OP_SHR:  alu_s[WIDTH-1:0] = y_q >> sh_s;
      OP_SHRA: alu_s[WIDTH-1:0] = $signed(y_q) >>> sh_s;
      OP_MUL:  alu_s            = ya_s * yb_s;
      OP_NEG:  alu_s[WIDTH-1:0] = {WIDTH{1'b0}} - y_q;
      OP_NOT:  alu_s[WIDTH-1:0] = ~y_q;
      OP_MFHI: alu_s[WIDTH-1:0] = hi_q;
      OP_MFLO: alu_s[WIDTH-1:0] = lo_q;
      default: alu_s            = '0;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      op_q    <= 4'd0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && start) begin
        op_q <= op;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
      if (state_q == S_T1) y_q <= regs_q[rb_q];
      if (state_q == S_T2) z_q <= alu_s;
      if (hilo_we_s) begin
        hi_q <= z_q[2*WIDTH-1:WIDTH];
        lo_q <= z_q[WIDTH-1:0];
      end
      // Handshake outputs trail the state by one edge so done lands in the 5th cycle.
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_DONE);
      err_q  <= (state_q == S_DONE) && illegal_s;
    end
  end

  // The sequencer write is issued last so it overrides a same-index external write.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (wr_en)    regs_q[wr_addr] <= wr_data;
      if (seq_we_s) regs_q[ra_q]    <= z_q[WIDTH-1:0];
      rd_q <= regs_q[rd_addr];
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_data = rd_q;
  assign hi_out  = hi_q;
  assign lo_out  = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed self-checking bench for bus_datapath_seq: a 32-bit/16-register instance
// and an 8-bit/4-register instance driven from hand-computed vectors.
module tb_bus_datapath_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [3:0]  ra = 4'd0, rb = 4'd0, rc = 4'd0;
  logic        busy, done, err;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  rd_addr = 4'd0;
  logic [31:0] rd_data, hi_out, lo_out;

  logic        b_start = 1'b0;
  logic [3:0]  b_op = 4'd0;
  logic [1:0]  b_ra = 2'd0, b_rb = 2'd0, b_rc = 2'd0;
  logic        b_busy, b_done, b_err;
  logic        b_wr_en = 1'b0;
  logic [1:0]  b_wr_addr = 2'd0;
  logic [7:0]  b_wr_data = 8'd0;
  logic [1:0]  b_rd_addr = 2'd0;
  logic [7:0]  b_rd_data, b_hi_out, b_lo_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clock = ~clock;

  bus_datapath_seq #(.WIDTH(32), .NREGS(16)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .busy(busy), .done(done), .err(err), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .hi_out(hi_out), .lo_out(lo_out)
  );

  bus_datapath_seq #(.WIDTH(8), .NREGS(4)) dut8 (
    .clock(clock), .clear(clear), .start(b_start), .op(b_op), .ra(b_ra), .rb(b_rb), .rc(b_rc),
    .busy(b_busy), .done(b_done), .err(b_err), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .hi_out(b_hi_out),
    .lo_out(b_lo_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock); wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock); wr_en = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clock); rd_addr = a;
    @(negedge clock); check_eq(tag, rd_data, exp);
  endtask

  // Counts negedges (starting at n0 on the current one) until done is seen, bounded.
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c, input logic exp_err);
    int n;
    @(negedge clock); start = 1'b1; op = o; ra = a; rb = b; rc = c;
    @(negedge clock); start = 1'b0;
    wait_done(1, n);
    check_eq({tag, "_latency"}, n, 5);
    check_eq({tag, "_err"}, err, exp_err);
    @(negedge clock);
    check_eq({tag, "_done_1cyc"}, done, 1'b0);
  endtask

  task automatic b_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clock); b_wr_en = 1'b1; b_wr_addr = a; b_wr_data = d;
    @(negedge clock); b_wr_en = 1'b0;
  endtask

  task automatic b_run(input string tag, input logic [3:0] o, input logic [1:0] a,
                       input logic [1:0] b, input logic [1:0] c);
    int n;
    @(negedge clock); b_start = 1'b1; b_op = o; b_ra = a; b_rb = b; b_rc = c;
    @(negedge clock); b_start = 1'b0;
    n = 1;
    while (!b_done && n < 20) begin
      @(negedge clock);
      n++;
    end
    check_eq({tag, "_latency"}, n, 5);
    check_eq({tag, "_err"}, b_err, 1'b0);
    @(negedge clock);
  endtask

  initial begin
    int n;
    int c1;
    int extra;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_hi", hi_out, 32'h0);
    check_eq("rst_lo", lo_out, 32'h0);

    wr(4'd2, 32'h0000_0005);
    wr(4'd3, 32'h0000_0007);
    run("add", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
    rd("add_r1", 4'd1, 32'h0000_000C);
    rd("add_r2_kept", 4'd2, 32'h0000_0005);

    wr(4'd5, 32'hFFFF_FFFF);
    wr(4'd6, 32'h0000_0002);
    run("add_wrap", 4'd0, 4'd4, 4'd5, 4'd6, 1'b0);
    rd("add_wrap_r4", 4'd4, 32'h0000_0001);

    wr(4'd7, 32'h8000_0000);
    wr(4'd8, 32'h0000_0004);
    run("shra", 4'd6, 4'd10, 4'd7, 4'd8, 1'b0);
    rd("shra_r10", 4'd10, 32'hF800_0000);
    run("shr", 4'd5, 4'd11, 4'd7, 4'd8, 1'b0);
    rd("shr_r11", 4'd11, 32'h0800_0000);
    run("shl", 4'd4, 4'd12, 4'd3, 4'd8, 1'b0);
    rd("shl_r12", 4'd12, 32'h0000_0070);
    run("sub", 4'd1, 4'd13, 4'd2, 4'd3, 1'b0);
    rd("sub_r13", 4'd13, 32'hFFFF_FFFE);
    run("and", 4'd2, 4'd14, 4'd5, 4'd7, 1'b0);
    rd("and_r14", 4'd14, 32'h8000_0000);
    run("or", 4'd3, 4'd15, 4'd2, 4'd7, 1'b0);
    rd("or_r15", 4'd15, 32'h8000_0005);
    run("neg", 4'd8, 4'd9, 4'd6, 4'd0, 1'b0);
    rd("neg_r9", 4'd9, 32'hFFFF_FFFE);
    run("not", 4'd9, 4'd9, 4'd7, 4'd0, 1'b0);
    rd("not_r9", 4'd9, 32'h7FFF_FFFF);

    wr(4'd2, 32'hFFFF_FFFE);
    wr(4'd3, 32'h0000_0003);
    run("mul", 4'd7, 4'd12, 4'd2, 4'd3, 1'b0);
    check_eq("mul_hi", hi_out, 32'hFFFF_FFFF);
    check_eq("mul_lo", lo_out, 32'hFFFF_FFFA);
    rd("mul_r12_kept", 4'd12, 32'h0000_0070);
    run("mflo", 4'd11, 4'd9, 4'd0, 4'd0, 1'b0);
    rd("mflo_r9", 4'd9, 32'hFFFF_FFFA);
    run("mfhi", 4'd10, 4'd13, 4'd0, 4'd0, 1'b0);
    rd("mfhi_r13", 4'd13, 32'hFFFF_FFFF);

    run("illegal", 4'd13, 4'd1, 4'd2, 4'd3, 1'b1);
    rd("illegal_r1_kept", 4'd1, 32'h0000_000C);
    check_eq("illegal_hi_kept", hi_out, 32'hFFFF_FFFF);
    check_eq("illegal_lo_kept", lo_out, 32'hFFFF_FFFA);

    // start pulsed while busy must not launch the NEG into R13
    @(negedge clock); start = 1'b1; op = 4'd0; ra = 4'd14; rb = 4'd2; rc = 4'd3;
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1; op = 4'd8; ra = 4'd13; rb = 4'd6;
    check_eq("busy_high", busy, 1'b1);
    @(negedge clock); start = 1'b0;
    wait_done(3, n);
    check_eq("ign_latency", n, 5);
    extra = 0;
    repeat (8) begin
      @(negedge clock);
      if (done) extra++;
    end
    check_eq("ign_no_extra_done", extra, 0);
    rd("ign_r14", 4'd14, 32'h0000_0001);
    rd("ign_r13_kept", 4'd13, 32'hFFFF_FFFF);

    wr(4'd2, 32'h0000_0005);
    wr(4'd3, 32'h0000_0007);
    wr(4'd1, 32'h0000_0000);
    @(negedge clock); start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hAAAA_AAAA;
    @(negedge clock); wr_en = 1'b0;
    wait_done(4, n);
    check_eq("coll_latency", n, 5);
    rd("coll_r1", 4'd1, 32'h0000_000C);

    @(negedge clock); start = 1'b1; op = 4'd0; ra = 4'd15; rb = 4'd2; rc = 4'd3;
    @(negedge clock); start = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h0000_0064;
    @(negedge clock); wr_en = 1'b0;
    wait_done(2, n);
    check_eq("early_wr_latency", n, 5);
    rd("early_wr_r15", 4'd15, 32'h0000_0069);

    @(negedge clock); start = 1'b1; op = 4'd0; ra = 4'd15; rb = 4'd15; rc = 4'd6;
    wait_done(0, c1);
    check_eq("b2b_first", c1, 5);
    @(negedge clock);
    wait_done(1, n);
    check_eq("b2b_interval", n, 5);
    start = 1'b0;
    repeat (6) @(negedge clock);
    rd("b2b_r15", 4'd15, 32'h0000_006D);

    @(negedge clock); start = 1'b1; op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3;
    @(negedge clock); start = 1'b0;
    @(negedge clock); clear = 1'b1;
    #1;
    check_eq("clr_busy", busy, 1'b0);
    check_eq("clr_done", done, 1'b0);
    check_eq("clr_err", err, 1'b0);
    check_eq("clr_rd", rd_data, 32'h0);
    check_eq("clr_hi", hi_out, 32'h0);
    check_eq("clr_lo", lo_out, 32'h0);
    @(negedge clock); clear = 1'b0;
    for (int i = 0; i < 16; i++) rd($sformatf("clr_r%0d", i), i[3:0], 32'h0);
    check_eq("clr_idle", busy, 1'b0);

    b_wr(2'd1, 8'h7F);
    b_wr(2'd2, 8'h01);
    b_run("w8_add", 4'd0, 2'd0, 2'd1, 2'd2);
    @(negedge clock); b_rd_addr = 2'd0;
    @(negedge clock); check_eq("w8_add_r0", b_rd_data, 8'h80);
    b_run("w8_mul", 4'd7, 2'd3, 2'd1, 2'd2);
    check_eq("w8_mul_hi", b_hi_out, 8'h00);
    check_eq("w8_mul_lo", b_lo_out, 8'h7F);
    @(negedge clock); b_rd_addr = 2'd3;
    @(negedge clock); check_eq("w8_mul_r3_kept", b_rd_data, 8'h00);
    check_eq("w8_idle", b_busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bus_datapath_seq.md
Name: bus_datapath_seq

Overview:
- Parametrised successor to the single-bus phase-1 datapath: a register file, Y/Z ALU staging registers and HI/LO, driven by a built-in T-state microsequencer instead of external per-register in/out strobes.
- A start/busy/done handshake issues one three-operand ALU instruction (Ra <= Rb op Rc), or a MUL into HI/LO.
- An external load/readback port lets the testbench, and later the control unit, preload and inspect registers.

Parameters:
- WIDTH, 32, data word width; power of 2, >= 8.
- NREGS, 16, number of general-purpose registers; power of 2, >= 2. Local AW = clog2(NREGS).

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- start  in  1  instruction request, sampled only in IDLE.
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR (logical), 6 SHRA (arithmetic), 7 MUL (signed), 8 NEG, 9 NOT, 10 MFHI, 11 MFLO, 12-15 illegal.
- ra  in  AW  destination register index.
- rb  in  AW  source A register index.
- rc  in  AW  source B register index.
- busy  out  1  high whenever the sequencer is not in IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when op was illegal.
- wr_en  in  1  external register write strobe.
- wr_addr  in  AW  external write index.
- wr_data  in  WIDTH  external write data.
- rd_addr  in  AW  external read index.
- rd_data  out  WIDTH  registered readback of R[rd_addr].
- hi_out  out  WIDTH  HI register contents.
- lo_out  out  WIDTH  LO register contents.

Behaviour:
- Reset: clear asynchronously forces the sequencer to IDLE and zeroes all R[i], Y, Z (2*WIDTH), HI, LO, rd_data, busy, done and err. Reset mid-instruction aborts it with no write-back.
- States: IDLE -> T1 -> T2 -> T3 -> DONE -> IDLE.
- IDLE: start=1 latches op/ra/rb/rc and moves to T1. start is ignored in every other state; no queueing.
- T1: Y <= R[rb].
- T2: Z <= ALU(Y, R[rc], op).
  - ADD/SUB/AND/OR: result in Z low, Z high = 0.
  - Shifts: amount = R[rc][clog2(WIDTH)-1:0].
  - MUL: full signed 2*WIDTH product.
  - NEG/NOT: use Y only.
  - MFHI/MFLO: Z low = HI/LO.
  - ADD/SUB wrap modulo 2^WIDTH; no flags.
- T3 (write-back): MUL writes HI <= Z[2W-1:W] and LO <= Z[W-1:0]; legal non-MUL ops write R[ra] <= Z[W-1:0]; illegal ops write nothing.
- DONE: done=1 for exactly one cycle; err=1 in the same cycle if op was 12-15. Return to IDLE.
- Timing: start sampled at edge 0 -> done high in the cycle after edge 4. busy is high from edge 1 through the DONE cycle, inclusive.
- Back-to-back: start held high re-issues the instruction at the first IDLE edge after DONE, so the issue interval is 5 cycles.
- External write: wr_en writes R[wr_addr] <= wr_data on any edge, including while busy.
  - Collision with T3 write-back to the same index: the sequencer wins.
  - An external write to rb/rc before T1/T2 samples it is seen by the running instruction.
- Readback: rd_data <= R[rd_addr] each edge (1-cycle latency), reflecting pre-edge contents. No write-through bypass.
- All registers, including index 0, are ordinary writable registers.

Test Plan:
- Reset: assert clear mid-T2 of an ADD -> busy, done and all outputs 0 immediately (asynchronous); after release, readback of every R[i] = 0.
- ADD, WIDTH=32: preload R2=0x0000_0005 and R3=0x0000_0007; start op=0, ra=1, rb=2, rc=3 -> done pulses in the 5th cycle; R1=0x0000_000C; err=0.
- Arithmetic: preload R5=0xFFFF_FFFF, R6=0x2, then ADD ra=4 -> R4=0x0000_0001 (wrap).
  - R7=0x8000_0000, R8=4: SHRA -> 0xF800_0000; SHR -> 0x0800_0000.
- MUL: R2=0xFFFF_FFFE (-2), R3=0x0000_0003, op=7 -> HI=0xFFFF_FFFF, LO=0xFFFF_FFFA; R[ra] unchanged.
  - Then MFLO ra=9 -> R9=0xFFFF_FFFA.
- Handshake and collision:
  - start pulsed during busy -> ignored.
  - Illegal op=13 -> done=1 and err=1 in the same cycle, no register change.
  - wr_en to R1 with 0xAAAA_AAAA in the same cycle as T3 write-back to R1 of 0x0000_000C -> R1=0x0000_000C.
- Parameter sweep: WIDTH=8, NREGS=4; R1=0x7F, R2=0x01, ADD -> R0=0x80; MUL -> HI=0x00, LO=0x7F.
